// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one two-port, read-first block RAM between NUM_REQ requesters.
//   After reset the RAM is zero-filled two words per cycle (port A even,
//   port B odd addresses). Then up to two requests per cycle are granted with
//   round-robin priority, one per RAM port. Read data returns to the issuing
//   requester two cycles after its handshake.
//
// Ports
//   clk, rst_n            : single clock, asynchronous active-low reset
//   init_done             : high once the zero-fill has completed
//   req_valid/req_we      : per-requester valid and write flag
//   req_addr/req_wdata    : flattened per-requester address and write data
//   req_ready             : per-requester grant (transfer on valid & ready)
//   rsp_valid/rsp_data    : per-requester read-response pulse and data
//   ena/wea/addra/dia     : registered RAM port A strobe
//   enb/web/addrb/dib     : registered RAM port B strobe
//   doa/dob               : RAM read data, one cycle after the enable is sampled
module ram_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  localparam int AW     = $clog2(DEPTH),
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     init_done,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_we,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [NUM_REQ*WIDTH-1:0] rsp_data,
  output logic                     ena,
  output logic                     enb,
  output logic                     wea,
  output logic                     web,
  output logic [AW-1:0]            addra,
  output logic [AW-1:0]            addrb,
  output logic [WIDTH-1:0]         dia,
  output logic [WIDTH-1:0]         dib,
  input  logic [WIDTH-1:0]         doa,
  input  logic [WIDTH-1:0]         dob
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic [IW-1:0] rr_ptr;

  // Arbitration results
  logic             a_hit, b_hit, a_go, b_go;
  logic [IW-1:0]    a_id, b_id;
  logic             a_we, b_we;
  logic [AW-1:0]    a_addr, b_addr;
  logic [WIDTH-1:0] a_wdata, b_wdata;

  // Read-tracking pipelines: stage 1 = strobe on the RAM, stage 2 = data back
  logic          a1_v, a2_v, b1_v, b2_v;
  logic [IW-1:0] a1_id, a2_id, b1_id, b2_id;

  // (base + k) mod NUM_REQ, valid for k < NUM_REQ; works for any NUM_REQ.
  function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s -= NUM_REQ;
    return IW'(s);
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    a_hit     = 1'b0;
    b_hit     = 1'b0;
    a_id      = '0;
    b_id      = '0;
    req_ready = '0;
    // First valid from rr_ptr wins port A; the next valid after it wins port B.
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid[rot_idx(rr_ptr, k)]) begin
        if (!a_hit) begin
          a_hit = 1'b1;
          a_id  = rot_idx(rr_ptr, k);
        end else if (!b_hit) begin
          b_hit = 1'b1;
          b_id  = rot_idx(rr_ptr, k);
        end
      end
    end
    a_we    = req_we[a_id];
    b_we    = req_we[b_id];
    a_addr  = req_addr[a_id*AW +: AW];
    b_addr  = req_addr[b_id*AW +: AW];
    a_wdata = req_wdata[a_id*WIDTH +: WIDTH];
    b_wdata = req_wdata[b_id*WIDTH +: WIDTH];
    a_go    = (state == RUN) && a_hit;
    // Same address on both ports with any write is a hazard: B waits a cycle.
    b_go    = (state == RUN) && b_hit && !((b_addr == a_addr) && (a_we || b_we));
    if (a_go) req_ready[a_id] = 1'b1;
    if (b_go) req_ready[b_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      init_done <= 1'b0;
      rr_ptr    <= '0;
      ena       <= 1'b0;
      enb       <= 1'b0;
      wea       <= 1'b0;
      web       <= 1'b0;
      addra     <= '0;
      addrb     <= '0;
      dia       <= '0;
      dib       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      case (state)
        CLEAR: begin
          ena     <= 1'b1;
          enb     <= 1'b1;
          wea     <= 1'b1;
          web     <= 1'b1;
          addra   <= clr_cnt;
          addrb   <= clr_cnt + AW'(1);
          dia     <= '0;
          dib     <= '0;
          clr_cnt <= clr_cnt + AW'(2);
          if (clr_cnt == AW'(DEPTH - 2)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          ena <= a_go;
          wea <= a_go && a_we;
          enb <= b_go;
          web <= b_go && b_we;
          // Idle ports keep their last address/data to avoid needless toggling.
          if (a_go) begin
            addra <= a_addr;
            dia   <= a_wdata;
          end
          if (b_go) begin
            addrb <= b_addr;
            dib   <= b_wdata;
          end
          // b_go implies a_go, so B (when granted) is the last winner.
          if (a_go) rr_ptr <= rot_idx(b_go ? b_id : a_id, 1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_v  <= 1'b0;
      a2_v  <= 1'b0;
      b1_v  <= 1'b0;
      b2_v  <= 1'b0;
      a1_id <= '0;
      a2_id <= '0;
      b1_id <= '0;
      b2_id <= '0;
    end else begin
      a1_v  <= a_go && !a_we;
      b1_v  <= b_go && !b_we;
      a1_id <= a_id;
      b1_id <= b_id;
      a2_v  <= a1_v;
      b2_v  <= b1_v;
      a2_id <= a1_id;
      b2_id <= b1_id;
    end
  end

  // Stage 2 lines up with RAM output data, so the response is steered directly.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (a2_v) begin
      rsp_valid[a2_id]                 = 1'b1;
      rsp_data[a2_id*WIDTH +: WIDTH]   = doa;
    end
    if (b2_v) begin
      rsp_valid[b2_id]                 = 1'b1;
      rsp_data[b2_id*WIDTH +: WIDTH]   = dob;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Directed bench for ram_port_arbiter (NUM_REQ=4, WIDTH=32, DEPTH=256) with a
//   behavioural two-port read-first RAM attached to the DUT's RAM ports.
module tb_ram_port_arbiter;

  logic         clk;
  logic         rst_n;
  logic         init_done;
  logic [3:0]   req_valid, req_we, req_ready, rsp_valid;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata, rsp_data;
  logic         ena, enb, wea, web;
  logic [7:0]   addra, addrb;
  logic [31:0]  dia, dib;
  logic [31:0]  doa = '0;
  logic [31:0]  dob = '0;

  int tests = 0;
  int fails = 0;

  ram_port_arbiter #(.NUM_REQ(4), .WIDTH(32), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dia(dia), .dib(dib),
    .doa(doa), .dob(dob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first RAM, pre-loaded with a non-zero pattern so the zero-fill shows.
  logic [31:0] mem [256] = '{default: 32'hA5A5A5A5};
  always @(posedge clk) begin
    if (ena) begin
      doa <= mem[addra];
      if (wea) mem[addra] <= dia;
    end
    if (enb) begin
      dob <= mem[addrb];
      if (web) mem[addrb] <= dib;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] we);
    req_valid = v;
    req_we    = we;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [31:0] d);
    req_addr[i*8 +: 8]   = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  // Called just after reset release with all four requesters asking to read.
  task automatic check_clear();
    for (int k = 0; k < 128; k++) begin
      tick();
      check("clr_strobe", 128'({ena, enb, wea, web}), 128'(4'hF));
      check("clr_addra", 128'(addra), 128'(2 * k));
      check("clr_addrb", 128'(addrb), 128'(2 * k + 1));
      check("clr_data", 128'({dia, dib}), 128'(0));
      check("clr_init", 128'(init_done), 128'(k == 127));
      check("clr_rsp", 128'(rsp_valid), 128'(0));
      if (k < 127) begin
        settle();
        check("clr_ready", 128'(req_ready), 128'(0));
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    tick();
    tick();
    check("rst_en", 128'({ena, enb, wea, web}), 128'(0));
    check("rst_addr", 128'({addra, addrb}), 128'(0));
    check("rst_data", 128'({dia, dib}), 128'(0));
    check("rst_init", 128'(init_done), 128'(0));
    check("rst_rsp", 128'(rsp_valid), 128'(0));

    // Zero-fill sweep; requests are held during it and must not be granted.
    set_req(0, 8'h7F, 32'h0);
    set_req(1, 8'h10, 32'h0);
    set_req(2, 8'h11, 32'h0);
    set_req(3, 8'h12, 32'h0);
    drive(4'hF, 4'h0);
    rst_n = 1'b1;
    check_clear();

    // First RUN cycle: requester 0 reads 0x7F (rr_ptr = 0).
    drive(4'b0001, 4'b0000);
    settle();
    check("run_first_ready", 128'(req_ready), 128'(4'b0001));
    tick();
    drive(4'b0000, 4'b0000);
    check("rd7f_strobe", 128'({ena, wea, addra}), 128'({1'b1, 1'b0, 8'h7F}));
    check("rd7f_enb", 128'(enb), 128'(0));
    settle();
    check("rd7f_lat1", 128'(rsp_valid), 128'(0));
    tick();
    check("rd7f_rsp", 128'(rsp_valid), 128'(4'b0001));
    check("rd7f_data", rsp_data, 128'(0));
    check("hold_addr", 128'({ena, addra}), 128'({1'b0, 8'h7F}));

    // Write then read-after-write (rr_ptr = 1).
    tick();
    set_req(0, 8'h05, 32'hDEADBEEF);
    drive(4'b0001, 4'b0001);
    settle();
    check("raw_wr_ready", 128'(req_ready), 128'(4'b0001));
    tick();
    set_req(1, 8'h05, 32'h0);
    drive(4'b0010, 4'b0000);
    check("raw_wr_strobe", 128'({ena, wea, addra, dia}), 128'({1'b1, 1'b1, 8'h05, 32'hDEADBEEF}));
    settle();
    check("raw_rd_ready", 128'(req_ready), 128'(4'b0010));
    tick();
    drive(4'b0000, 4'b0000);
    check("raw_no_wr_rsp", 128'(rsp_valid), 128'(0));
    check("raw_rd_strobe", 128'({ena, wea, addra}), 128'({1'b1, 1'b0, 8'h05}));
    tick();
    check("raw_rsp", 128'(rsp_valid), 128'(4'b0010));
    check("raw_data", rsp_data, {64'h0, 32'hDEADBEEF, 32'h0});

    // Dual write on both ports (rr_ptr = 2).
    tick();
    set_req(2, 8'h11, 32'h22222222);
    set_req(3, 8'h12, 32'h33333333);
    drive(4'b1100, 4'b1100);
    settle();
    check("dual_wr_ready", 128'(req_ready), 128'(4'b1100));
    tick();
    check("dual_wr_a", 128'({ena, wea, addra, dia}), 128'({1'b1, 1'b1, 8'h11, 32'h22222222}));
    check("dual_wr_b", 128'({enb, web, addrb, dib}), 128'({1'b1, 1'b1, 8'h12, 32'h33333333}));

    // Streaming reads from all four requesters (rr_ptr = 0).
    set_req(0, 8'h05, 32'h0);
    set_req(1, 8'h10, 32'h0);
    set_req(2, 8'h11, 32'h0);
    set_req(3, 8'h12, 32'h0);
    drive(4'hF, 4'h0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      settle();
      check("stream_ready", 128'(req_ready), 128'((i % 2 == 0) ? 4'b0011 : 4'b1100));
      if (i < 2) begin
        check("stream_rsp", 128'(rsp_valid), 128'(0));
      end else if (i % 2 == 0) begin
        check("stream_rsp", 128'(rsp_valid), 128'(4'b0011));
        check("stream_data", rsp_data, {96'h0, 32'hDEADBEEF});
      end else begin
        check("stream_rsp", 128'(rsp_valid), 128'(4'b1100));
        check("stream_data", rsp_data, {32'h33333333, 32'h22222222, 64'h0});
      end
    end
    tick();
    drive(4'b0000, 4'b0000);
    settle();
    check("stream_idle_ready", 128'(req_ready), 128'(0));
    check("stream_tail0", 128'(rsp_valid), 128'(4'b0011));
    check("stream_tail0_data", rsp_data, {96'h0, 32'hDEADBEEF});
    tick();
    check("stream_tail1", 128'(rsp_valid), 128'(4'b1100));
    check("stream_tail1_data", rsp_data, {32'h33333333, 32'h22222222, 64'h0});

    // Write/read hazard on address 9 (rr_ptr = 0).
    tick();
    set_req(0, 8'h09, 32'h99999999);
    set_req(1, 8'h09, 32'h0);
    drive(4'b0011, 4'b0001);
    settle();
    check("hazard_ready", 128'(req_ready), 128'(4'b0001));
    tick();
    drive(4'b0010, 4'b0000);
    check("hazard_a", 128'({ena, wea, addra}), 128'({1'b1, 1'b1, 8'h09}));
    check("hazard_enb", 128'(enb), 128'(0));
    settle();
    check("hazard_retry_ready", 128'(req_ready), 128'(4'b0010));
    tick();
    drive(4'b0000, 4'b0000);
    settle();
    check("hazard_no_rsp", 128'(rsp_valid), 128'(0));
    tick();
    check("hazard_rsp", 128'(rsp_valid), 128'(4'b0010));
    check("hazard_data", rsp_data, {64'h0, 32'h99999999, 32'h0});

    // Read-read to the same address on both ports (rr_ptr = 2).
    tick();
    set_req(2, 8'h09, 32'h0);
    set_req(3, 8'h09, 32'h0);
    drive(4'b1100, 4'b0000);
    settle();
    check("rr_same_ready", 128'(req_ready), 128'(4'b1100));
    tick();
    drive(4'b0000, 4'b0000);
    check("rr_same_strobe", 128'({ena, addra, enb, addrb, web}), 128'({1'b1, 8'h09, 1'b1, 8'h09, 1'b0}));
    tick();
    check("rr_same_rsp", 128'(rsp_valid), 128'(4'b1100));
    check("rr_same_data", rsp_data, {32'h99999999, 32'h99999999, 64'h0});

    // Reset one cycle after a read handshake (rr_ptr = 0).
    tick();
    set_req(0, 8'h09, 32'h0);
    drive(4'b0001, 4'b0000);
    settle();
    check("mid_rd_ready", 128'(req_ready), 128'(4'b0001));
    tick();
    drive(4'b0000, 4'b0000);
    check("mid_rd_strobe", 128'(ena), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", 128'({ena, enb, wea, web}), 128'(0));
    check("mid_rst_init", 128'(init_done), 128'(0));
    check("mid_rst_rsp", 128'(rsp_valid), 128'(0));
    tick();
    check("mid_rst_rsp_t2", 128'(rsp_valid), 128'(0));
    tick();
    set_req(0, 8'h7F, 32'h0);
    set_req(1, 8'h10, 32'h0);
    set_req(2, 8'h11, 32'h0);
    set_req(3, 8'h12, 32'h0);
    drive(4'hF, 4'h0);
    rst_n = 1'b1;
    check_clear();
    drive(4'b0000, 4'b0000);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
